// File: rtl/overdrive_pipe.sv
// Purpose: per-channel overdrive (gain, then hard or soft clip) on a TDM audio stream.
// Latency: 3 cycles from acceptance to out_valid (S1 multiply, S2 shape, S3 output).
// Backpressure: whole pipe freezes while out_valid && !out_ready; in_ready drops the same cycle.
//
// Ports: clk/rst_n (async active-low); in_valid/in_ready/audio_in/ch_in/address_in/en = sample in;
//        set_magnitude/mag_ch/magnitude/mode = per-channel config write strobe;
//        out_valid/out_ready/audio_out/ch_out/address_out = sample out.
module overdrive_pipe #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 32,
    parameter int NCH    = 2,
    parameter int MAG_W  = 4,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] audio_in,
    input  logic [CH_W-1:0]          ch_in,
    input  logic [ADDR_W-1:0]        address_in,
    input  logic                     en,
    input  logic                     set_magnitude,
    input  logic [CH_W-1:0]          mag_ch,
    input  logic [MAG_W-1:0]         magnitude,
    input  logic [1:0]               mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] audio_out,
    output logic [CH_W-1:0]          ch_out,
    output logic [ADDR_W-1:0]        address_out
);

    // Product width: DATA_W-bit signed sample times an unsigned gain of up to 2^MAG_W.
    localparam int PW = DATA_W + MAG_W + 1;
    localparam logic [PW-1:0] K    = PW'(1) << (DATA_W - 2);
    localparam logic [PW-1:0] MAXV = (PW'(1) << (DATA_W - 1)) - PW'(1);

    // ---------------- per-channel configuration ----------------
    logic [MAG_W-1:0] mag_r  [NCH];
    logic [1:0]       mode_r [NCH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                mag_r[c]  <= '0;
                mode_r[c] <= 2'd1;
            end
        end else if (set_magnitude && (32'(mag_ch) < NCH)) begin
            mag_r[mag_ch]  <= magnitude;
            mode_r[mag_ch] <= mode;
        end
    end

    // Registered config is read here, so a write coinciding with acceptance
    // only affects the following samples. Unknown channels get G=1, hard clip.
    logic [MAG_W-1:0] sel_mag;
    logic [1:0]       sel_mode;

    always_comb begin
        sel_mag  = '0;
        sel_mode = 2'd1;
        if (32'(ch_in) < NCH) begin
            sel_mag  = mag_r[ch_in];
            sel_mode = mode_r[ch_in];
        end
    end

    // ---------------- flow control ----------------
    assign in_ready = !(out_valid && !out_ready);

    // ---------------- S1: multiply ----------------
    logic [MAG_W:0]          gain;
    logic signed [PW-1:0]    a_ext;
    logic signed [PW-1:0]    g_ext;
    logic signed [PW-1:0]    prod;

    assign gain  = {1'b0, sel_mag} + (MAG_W+1)'(1);
    assign a_ext = {{(PW-DATA_W){audio_in[DATA_W-1]}}, audio_in};
    assign g_ext = {{(PW-MAG_W-1){1'b0}}, gain};
    assign prod  = a_ext * g_ext;

    logic                     s1_vld;
    logic signed [PW-1:0]     s1_p;
    logic                     s1_byp;
    logic                     s1_soft;
    logic [DATA_W-1:0]        s1_raw;
    logic [CH_W-1:0]          s1_ch;
    logic [ADDR_W-1:0]        s1_addr;

    // ---------------- S2: shape (combinational from S1) ----------------
    // Work on |P| so that soft-clip and symmetric saturation share one path;
    // the sign is reapplied at the end, so -2^(DATA_W-1) is never produced.
    logic              p_neg;
    logic [PW-1:0]     p_abs;
    logic [PW-1:0]     soft_abs;
    logic [PW-1:0]     shaped_abs;
    logic [PW-1:0]     sat_abs;
    logic [PW-1:0]     y_full;
    logic [DATA_W-1:0] y_nxt;

    always_comb begin
        p_neg      = s1_p[PW-1];
        p_abs      = p_neg ? -s1_p : s1_p;
        soft_abs   = (p_abs > K) ? (K + ((p_abs - K) >> 2)) : p_abs;
        shaped_abs = s1_soft ? soft_abs : p_abs;
        sat_abs    = (shaped_abs > MAXV) ? MAXV : shaped_abs;
        y_full     = p_neg ? -sat_abs : sat_abs;
        y_nxt      = s1_byp ? s1_raw : DATA_W'(y_full);
    end

    logic                 s2_vld;
    logic [DATA_W-1:0]    s2_y;
    logic [CH_W-1:0]      s2_ch;
    logic [ADDR_W-1:0]    s2_addr;

    // ---------------- pipeline registers (S1, S2, S3) ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld      <= 1'b0;
            s1_p        <= '0;
            s1_byp      <= 1'b0;
            s1_soft     <= 1'b0;
            s1_raw      <= '0;
            s1_ch       <= '0;
            s1_addr     <= '0;
            s2_vld      <= 1'b0;
            s2_y        <= '0;
            s2_ch       <= '0;
            s2_addr     <= '0;
            out_valid   <= 1'b0;
            audio_out   <= '0;
            ch_out      <= '0;
            address_out <= '0;
        end else if (in_ready) begin
            s1_vld      <= in_valid;
            s1_p        <= prod;
            s1_byp      <= !en || (sel_mode == 2'd0);
            s1_soft     <= (sel_mode == 2'd2);
            s1_raw      <= audio_in;
            s1_ch       <= ch_in;
            s1_addr     <= address_in;

            s2_vld      <= s1_vld;
            s2_y        <= y_nxt;
            s2_ch       <= s1_ch;
            s2_addr     <= s1_addr;

            out_valid   <= s2_vld;
            audio_out   <= s2_y;
            ch_out      <= s2_ch;
            address_out <= s2_addr;
        end
    end

endmodule
